cpu_irq_dispatch: RTL and testbench
===================================

# cpu_irq_dispatch

Trap-entry and trap-return sequencer inside the CPU. It consumes the pending-interrupt request and handler vector from the CSR unit and stalls fetch until the pipeline drains at an instruction boundary. It then redirects fetch to the handler and returns the dispatch acknowledge plus the saved resume PC to the CSR unit. On a committed MRET it redirects fetch back to the CSR-held exception PC. Nested traps are not supported.

## Interface
- RESET_PC, 32'h0000_0000: initial value of the resume-PC register before any instruction commits.
- i_clock  in  1  rising-edge clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_irq_pending  in  1  CSR reports an enabled interrupt/ecall pending.
- i_irq_pc  in  32  handler vector (CSR mtvec copy).
- o_irq_dispatched  out  1  one-cycle acknowledge to CSR; CSR clears pending and latches o_irq_epc.
- o_irq_epc  out  32  resume PC handed to CSR on dispatch.
- i_epc  in  32  CSR mepc, target for MRET.
- i_commit_valid  in  1  an instruction retired this cycle.
- i_commit_next_pc  in  32  architectural PC of the next instruction after the retiring one.
- i_pipe_empty  in  1  no instruction issued past fetch remains uncommitted.
- i_mret  in  1  MRET retired this cycle.
- o_stall_fetch  out  1  fetch must not issue new instructions.
- o_flush  out  1  discard all in-flight and fetched instructions this cycle.
- o_jump  out  1  load fetch PC from o_jump_pc this cycle.
- o_jump_pc  out  32  redirect target.
- o_in_handler  out  1  trap handler active.

## Operation
- Resume-PC register `epc_q`. It loads i_commit_next_pc on every cycle with i_commit_valid=1, in all states. The reset value is RESET_PC.
- FSM states: IDLE, DRAIN, DISPATCH, HANDLER, RETURN.
- IDLE:
  - All control outputs are 0.
  - i_irq_pending=1 moves to DRAIN.
  - i_mret is ignored.
- DRAIN:
  - o_stall_fetch=1.
  - If i_irq_pending drops, return to IDLE (abort; stall released next cycle).
  - Otherwise, i_pipe_empty=1 moves to DISPATCH.
  - i_mret is ignored.
- DISPATCH (exactly 1 cycle):
  - o_irq_dispatched=1, o_flush=1, o_jump=1, o_stall_fetch=1.
  - o_jump_pc=i_irq_pc.
  - o_irq_epc=`epc_q`.
  - Next state is HANDLER.
- HANDLER:
  - o_in_handler=1. All other control outputs are 0.
  - i_irq_pending is ignored (no nesting).
  - i_mret=1 moves to RETURN.
- RETURN (exactly 1 cycle):
  - o_flush=1, o_jump=1, o_stall_fetch=1.
  - o_jump_pc=i_epc (sampled this cycle).
  - o_in_handler=1.
  - Next state is IDLE.
- o_irq_epc and o_jump_pc are 0 in every state where they are not driven as above.
- All outputs are a decode of state plus `epc_q`, with the input pass-through of i_irq_pc and i_epc in DISPATCH and RETURN only. No output depends on any other input combinationally.

## Timing
- Reset (async, any state): state goes to IDLE immediately, `epc_q`=RESET_PC, and every output is 0.
- Reset release: the first FSM transition occurs on the first rising edge with i_reset_n=1.
- Pending sampled in IDLE at edge N: o_stall_fetch=1 from cycle N+1.
- Pipe empty sampled in DRAIN at edge K: DISPATCH is cycle K+1 and HANDLER is from cycle K+2.
- Minimum pending-to-dispatch latency is 2 cycles (pipe already empty).
- MRET at edge M in HANDLER: RETURN is cycle M+1 and IDLE is from M+2.
- Pending still high in IDLE after RETURN re-enters DRAIN one cycle later.
- Same-edge commit and pipe empty in DRAIN: `epc_q` takes that commit's next PC before DISPATCH, so the dispatch uses the latest commit.
- o_irq_dispatched is never high for two consecutive cycles.
- Between two dispatches there is at least one RETURN.

## Test plan
- Reset mid-DRAIN, asserted asynchronously between edges: all outputs go to 0 without a clock edge. After release with pending=0, the block stays in IDLE with o_stall_fetch=0.
- Empty pipe, pending=1, i_irq_pc=0x100, last commit next PC 0x2C:
  - stall at cycle +1;
  - at cycle +2: dispatched=1, flush=1, jump=1, jump_pc=0x100, o_irq_epc=0x2C;
  - in_handler=1 from cycle +3.
- Pending while two instructions are in flight, commits with next PC 0x40 then 0x44, pipe_empty on the second commit: dispatch reports o_irq_epc=0x44 on the cycle after the second commit.
- Pending drops during DRAIN: return to IDLE, no dispatched pulse, stall=0 next cycle.
- In HANDLER, pending reasserted: no second dispatch. Then mret with i_epc=0x44: next cycle jump=1, flush=1, jump_pc=0x44; the following cycle is IDLE, and the still-high pending causes DRAIN one cycle later.
- mret pulsed in IDLE and in DRAIN: no jump, no flush, state unchanged.

Source files
------------

// File: rtl/cpu_irq_dispatch.sv
// cpu_irq_dispatch: trap-entry/return sequencer; drains the pipe, redirects fetch
// to the handler, and jumps back to the CSR-held exception PC on MRET.
module cpu_irq_dispatch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_irq_pending,
  input  logic [31:0] i_irq_pc,
  output logic        o_irq_dispatched,
  output logic [31:0] o_irq_epc,
  input  logic [31:0] i_epc,
  input  logic        i_commit_valid,
  input  logic [31:0] i_commit_next_pc,
  input  logic        i_pipe_empty,
  input  logic        i_mret,
  output logic        o_stall_fetch,
  output logic        o_flush,
  output logic        o_jump,
  output logic [31:0] o_jump_pc,
  output logic        o_in_handler
);
  typedef enum logic [2:0] {IDLE, DRAIN, DISPATCH, HANDLER, RETURN} state_e;
  state_e      state_q, state_d;
  logic [31:0] epc_q;
  // resume PC tracks every commit, so a same-edge commit lands before dispatch
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= IDLE;
      epc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (i_commit_valid) epc_q <= i_commit_next_pc;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = i_irq_pending ? DRAIN : IDLE;
      DRAIN:    state_d = !i_irq_pending ? IDLE : (i_pipe_empty ? DISPATCH : DRAIN);
      DISPATCH: state_d = HANDLER;
      HANDLER:  state_d = i_mret ? RETURN : HANDLER;
      RETURN:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  assign o_irq_dispatched = state_q == DISPATCH;
  assign o_irq_epc        = state_q == DISPATCH ? epc_q : 32'h0;
  assign o_stall_fetch    = state_q == DRAIN || state_q == DISPATCH || state_q == RETURN;
  assign o_flush          = state_q == DISPATCH || state_q == RETURN;
  assign o_jump           = o_flush;
  assign o_jump_pc        = state_q == DISPATCH ? i_irq_pc : (state_q == RETURN ? i_epc : 32'h0);
  assign o_in_handler     = state_q == HANDLER || state_q == RETURN;
endmodule

// File: tb/tb_cpu_irq_dispatch.sv
// tb_cpu_irq_dispatch: directed stimulus, per-cycle model comparison and literal spot checks.
module tb_cpu_irq_dispatch;
  logic        clk = 0, rst_n = 0;
  logic        irq_pending = 0, commit_valid = 0, pipe_empty = 0, mret = 0;
  logic [31:0] irq_pc = 0, epc = 0, commit_next_pc = 0;
  logic        dispatched, stall, flush, jump, in_handler;
  logic [31:0] irq_epc, jump_pc;
  int          checks = 0, failures = 0;

  cpu_irq_dispatch dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_irq_pending(irq_pending), .i_irq_pc(irq_pc),
    .o_irq_dispatched(dispatched), .o_irq_epc(irq_epc), .i_epc(epc),
    .i_commit_valid(commit_valid), .i_commit_next_pc(commit_next_pc),
    .i_pipe_empty(pipe_empty), .i_mret(mret), .o_stall_fetch(stall), .o_flush(flush),
    .o_jump(jump), .o_jump_pc(jump_pc), .o_in_handler(in_handler)
  );

  always #5 clk = ~clk;

  // model: trap progress as flags (waiting for drain, dispatching, in handler, returning)
  bit          m_wait, m_disp, m_hand, m_ret;
  logic [31:0] m_epc = 32'h0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {m_wait, m_disp, m_hand, m_ret} = 4'b0;
      m_epc = 32'h0;
    end else begin
      bit busy;
      busy   = m_wait | m_disp | m_hand | m_ret;
      m_ret  = m_hand && mret;
      m_hand = m_disp || (m_hand && !mret);
      m_disp = m_wait && irq_pending && pipe_empty;
      m_wait = irq_pending && !pipe_empty && (m_wait || !busy) || (!busy && irq_pending);
      if (m_disp) m_wait = 0;
      if (commit_valid) m_epc = commit_next_pc;
    end

  logic [68:0] act, exp_v;
  bit          prev_disp = 0, saw_ret = 1;
  always @(negedge clk) begin
    act   = {dispatched, irq_epc, stall, flush, jump, jump_pc, in_handler};
    exp_v = {m_disp, m_disp ? m_epc : 32'h0, m_wait | m_disp | m_ret, m_disp | m_ret,
             m_disp | m_ret, m_disp ? irq_pc : (m_ret ? epc : 32'h0), m_hand | m_ret};
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp_v);
    end
    if (!rst_n) begin
      prev_disp = 0;
      saw_ret = 1;
    end else if (dispatched) begin
      checks++;
      if (prev_disp || !saw_ret) begin
        failures++;
        $display("FAIL dispatch_spacing t=%0t prev=%0b saw_return=%0b required prev=0 saw_return=1",
                 $time, prev_disp, saw_ret);
      end
      saw_ret = 0;
    end else if (jump) saw_ret = 1;
    prev_disp = dispatched;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    rst_n = 1;
    #1;
    chk("post_reset_stall", {31'b0, stall}, 0);
    chk("post_reset_jump_pc", jump_pc, 0);
    // async reset while draining
    irq_pending = 1;
    step();
    #1 chk("drain_stall", {31'b0, stall}, 1);
    #1 rst_n = 0;
    #1;
    chk("async_rst_outs", {27'b0, dispatched, stall, flush, jump, in_handler}, 0);
    chk("async_rst_pc", jump_pc | irq_epc, 0);
    irq_pending = 0;
    step();
    step();
    rst_n = 1;
    step();
    step();
    chk("idle_after_rst", {31'b0, stall}, 0);
    // empty pipe dispatch
    commit_valid = 1; commit_next_pc = 32'h2C; pipe_empty = 1;
    step();
    commit_valid = 0; irq_pending = 1; irq_pc = 32'h100;
    step();
    #1 chk("b_stall", {30'b0, stall, dispatched}, 32'b10);
    step();
    #1 chk("b_disp_ctl", {28'b0, dispatched, flush, jump, stall}, 32'hF);
    chk("b_jump_pc", jump_pc, 32'h100);
    chk("b_irq_epc", irq_epc, 32'h2C);
    irq_pending = 0;
    step();
    #1 chk("b_handler", {29'b0, in_handler, stall, jump}, 32'b100);
    // nesting attempt then MRET
    irq_pending = 1;
    step();
    step();
    #1 chk("no_nest", {30'b0, dispatched, in_handler}, 32'b01);
    mret = 1; epc = 32'h44;
    step();
    #1 chk("ret_ctl", {28'b0, jump, flush, stall, in_handler}, 32'hF);
    chk("ret_jump_pc", jump_pc, 32'h44);
    mret = 0;
    step();
    #1 chk("ret_idle", {30'b0, stall, in_handler}, 0);
    step();
    #1 chk("re_drain", {31'b0, stall}, 1);
    // abort during drain
    irq_pending = 0;
    step();
    #1 chk("abort_idle", {30'b0, stall, dispatched}, 0);
    // two commits in flight
    pipe_empty = 0; irq_pending = 1;
    step();
    commit_valid = 1; commit_next_pc = 32'h40;
    step();
    commit_next_pc = 32'h44; pipe_empty = 1;
    step();
    #1 chk("c_disp", {31'b0, dispatched}, 1);
    chk("c_irq_epc", irq_epc, 32'h44);
    commit_valid = 0; irq_pending = 0; pipe_empty = 0;
    step();
    mret = 1; epc = 32'h80;
    step();
    #1 chk("c_ret_pc", jump_pc, 32'h80);
    mret = 0;
    step();
    // mret ignored in IDLE and DRAIN
    mret = 1;
    step();
    #1 chk("mret_idle", {29'b0, jump, flush, stall}, 0);
    irq_pending = 1;
    step();
    step();
    #1 chk("mret_drain", {28'b0, jump, flush, stall, in_handler}, 32'b0010);
    irq_pending = 0; mret = 0;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
